// File: rtl/teclado_pkg.sv
// Shared constants and types for the PS/2 keyboard event capture block.
// An event packs {ext, rel, code}; ext = E0 prefix seen, rel = F0 (release) seen.
package teclado_pkg;

    localparam logic [7:0] CODIGO_EXT    = 8'hE0;
    localparam logic [7:0] CODIGO_SOLTAR = 8'hF0;
    localparam int         ANCHO_EVENTO  = 10;

    typedef enum logic [1:0] {
        INACTIVO  = 2'd0,
        PREF_E0   = 2'd1,
        PREF_F0   = 2'd2,
        PREF_E0F0 = 2'd3
    } estado_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evento_t;

    function automatic logic es_prefijo(input logic [7:0] codigo);
        return (codigo == CODIGO_EXT) || (codigo == CODIGO_SOLTAR);
    endfunction

endpackage

// File: rtl/fifo_eventos_teclado.sv
// First-word-fall-through event FIFO with occupancy count and sticky overflow flag.
// The head reads as all zeros while the FIFO is empty.
module fifo_eventos_teclado #(
    parameter int PROFUNDIDAD = 8,
    parameter int ANCHO       = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         limpiar,
    input  logic                         escribir,
    input  logic [ANCHO-1:0]             dato,
    input  logic                         leer,
    output logic [ANCHO-1:0]             cabeza,
    output logic                         vacio,
    output logic                         lleno,
    output logic [$clog2(PROFUNDIDAD):0] conteo,
    output logic                         desbordado
);

    localparam int AP = $clog2(PROFUNDIDAD);
    localparam logic [AP:0] CUENTA_LLENA = (AP+1)'(PROFUNDIDAD);

    logic [ANCHO-1:0] mem [PROFUNDIDAD];
    logic [AP-1:0]    rd_ptr;
    logic [AP-1:0]    wr_ptr;
    logic             pop;
    logic             push;
    logic             perdida;

    assign vacio = (conteo == '0);
    assign lleno = (conteo == CUENTA_LLENA);

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign pop     = leer && !vacio;
    assign push    = escribir && (!lleno || pop);
    assign perdida = escribir && lleno && !leer;

    assign cabeza = vacio ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            conteo     <= '0;
            desbordado <= 1'b0;
        end else if (limpiar) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            conteo     <= '0;
            desbordado <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   conteo <= conteo + 1'b1;
                2'b01:   conteo <= conteo - 1'b1;
                default: conteo <= conteo;
            endcase
            if (perdida) begin
                desbordado <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !limpiar) begin
            mem[wr_ptr] <= dato;
        end
    end

endmodule

// File: rtl/captura_teclado_ext.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and queues press/release events
// into an event FIFO. MODO=0 keeps releases only, MODO=1 keeps both.
module captura_teclado_ext
    import teclado_pkg::*;
#(
    parameter int PROFUNDIDAD = 8,
    parameter int MODO        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   datoEntrada,
    input  logic                         rxListo,
    input  logic                         leer,
    input  logic                         limpiar,
    output logic [7:0]                   datoListo,
    output logic                         extendido,
    output logic                         soltado,
    output logic                         vacio,
    output logic                         lleno,
    output logic [$clog2(PROFUNDIDAD):0] conteo,
    output logic                         desbordado
);

    estado_t                 estado;
    logic                    rx_prev;
    logic                    armado;
    logic                    aceptar;
    logic                    emitir;
    logic                    escribir;
    evento_t                 evento;
    logic [ANCHO_EVENTO-1:0] cabeza;

    // armado blocks a level that was already high when reset released;
    // rxListo must be seen low once before any rising edge counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev <= 1'b0;
            armado  <= 1'b0;
        end else begin
            rx_prev <= rxListo;
            if (!rxListo) begin
                armado <= 1'b1;
            end
        end
    end

    assign aceptar = rxListo && !rx_prev && armado;

    always_comb begin
        emitir     = 1'b0;
        evento     = '0;
        evento.code = datoEntrada;
        evento.ext = (estado == PREF_E0) || (estado == PREF_E0F0);
        evento.rel = (estado == PREF_F0) || (estado == PREF_E0F0);
        if (aceptar && !es_prefijo(datoEntrada)) begin
            emitir = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= INACTIVO;
        end else if (aceptar) begin
            case (estado)
                INACTIVO: begin
                    if (datoEntrada == CODIGO_EXT) begin
                        estado <= PREF_E0;
                    end else if (datoEntrada == CODIGO_SOLTAR) begin
                        estado <= PREF_F0;
                    end
                end
                PREF_E0: begin
                    if (datoEntrada == CODIGO_SOLTAR) begin
                        estado <= PREF_E0F0;
                    end else if (datoEntrada != CODIGO_EXT) begin
                        estado <= INACTIVO;
                    end
                end
                PREF_F0: begin
                    if (datoEntrada == CODIGO_EXT) begin
                        estado <= PREF_E0F0;
                    end else if (datoEntrada != CODIGO_SOLTAR) begin
                        estado <= INACTIVO;
                    end
                end
                PREF_E0F0: begin
                    if (!es_prefijo(datoEntrada)) begin
                        estado <= INACTIVO;
                    end
                end
                default: estado <= INACTIVO;
            endcase
        end
    end

    assign escribir = emitir && ((MODO != 0) || evento.rel);

    fifo_eventos_teclado #(
        .PROFUNDIDAD (PROFUNDIDAD),
        .ANCHO       (ANCHO_EVENTO)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .limpiar    (limpiar),
        .escribir   (escribir),
        .dato       (evento),
        .leer       (leer),
        .cabeza     (cabeza),
        .vacio      (vacio),
        .lleno      (lleno),
        .conteo     (conteo),
        .desbordado (desbordado)
    );

    assign {extendido, soltado, datoListo} = cabeza;

endmodule

// File: tb/tb_captura_teclado_ext.sv
// Bench for captura_teclado_ext: dut0 is depth 8 / releases only, dut1 is depth 4 / both.
// Expected events are queued as stimulus is sent and compared as the FIFO drains.
module tb_captura_teclado_ext;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dato0, dato1;
    logic       rx0, rx1, leer0, leer1, limp0, limp1;
    logic [7:0] dl0, dl1;
    logic       ex0, ex1, so0, so1, va0, va1, ll0, ll1, de0, de1;
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] exp_ev;
    int         errors = 0;
    int         checks = 0;

    wire [9:0] head0 = {ex0, so0, dl0};
    wire [9:0] head1 = {ex1, so1, dl1};

    always #5 clk = ~clk;

    captura_teclado_ext #(.PROFUNDIDAD(8), .MODO(0)) dut0 (
        .clk(clk), .reset(reset), .datoEntrada(dato0), .rxListo(rx0), .leer(leer0),
        .limpiar(limp0), .datoListo(dl0), .extendido(ex0), .soltado(so0), .vacio(va0),
        .lleno(ll0), .conteo(cnt0), .desbordado(de0));

    captura_teclado_ext #(.PROFUNDIDAD(4), .MODO(1)) dut1 (
        .clk(clk), .reset(reset), .datoEntrada(dato1), .rxListo(rx1), .leer(leer1),
        .limpiar(limp1), .datoListo(dl1), .extendido(ex1), .soltado(so1), .vacio(va1),
        .lleno(ll1), .conteo(cnt1), .desbordado(de1));

    task automatic send(input int sel, input logic [7:0] b, input logic rd, input logic fl);
        @(negedge clk);
        if (sel == 0) begin
            dato0 = b; rx0 = 1'b1; leer0 = rd; limp0 = fl;
        end else begin
            dato1 = b; rx1 = 1'b1; leer1 = rd; limp1 = fl;
        end
        @(negedge clk);
        rx0 = 1'b0; leer0 = 1'b0; limp0 = 1'b0;
        rx1 = 1'b0; leer1 = 1'b0; limp1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        if (sel == 0) leer0 = 1'b1; else leer1 = 1'b1;
        @(negedge clk);
        leer0 = 1'b0; leer1 = 1'b0;
    endtask

    task automatic drain0(input string name);
        while (q0.size() > 0) begin
            exp_ev = q0.pop_front();
            checks++;
            if (head0 !== exp_ev || va0 !== 1'b0) begin
                errors++;
                $display("FAIL %s head0 got=%h vacio=%b want=%h", name, head0, va0, exp_ev);
            end
            pop(0);
        end
        checks++;
        if (va0 !== 1'b1) begin
            errors++;
            $display("FAIL %s_empty vacio0 got=%b want=1", name, va0);
        end
    endtask

    task automatic drain1(input string name);
        while (q1.size() > 0) begin
            exp_ev = q1.pop_front();
            checks++;
            if (head1 !== exp_ev || va1 !== 1'b0) begin
                errors++;
                $display("FAIL %s head1 got=%h vacio=%b want=%h", name, head1, va1, exp_ev);
            end
            pop(1);
        end
        checks++;
        if (va1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_empty vacio1 got=%b want=1", name, va1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({va0, ll0, cnt0, head0, de0} !== {1'b1, 1'b0, 4'd0, 10'h000, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut0 got vacio=%b lleno=%b conteo=%0d head=%h desb=%b", va0, ll0, cnt0, head0, de0);
        end
        checks++;
        if ({va1, ll1, cnt1, head1, de1} !== {1'b1, 1'b0, 3'd0, 10'h000, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut1 got vacio=%b lleno=%b conteo=%0d head=%h desb=%b", va1, ll1, cnt1, head1, de1);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_release_only();
        send(0, 8'hE1, 0, 0);
        send(0, 8'hF0, 0, 0);
        send(0, 8'hE1, 0, 0);
        q0.push_back({1'b0, 1'b1, 8'hE1});
        checks++;
        if (cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL release_only conteo got=%0d want=1", cnt0);
        end
        drain0("release_only");
    endtask

    task automatic test_extended();
        send(1, 8'hE0, 0, 0);
        send(1, 8'h75, 0, 0);
        q1.push_back({1'b1, 1'b0, 8'h75});
        send(1, 8'hE0, 0, 0);
        send(1, 8'hF0, 0, 0);
        send(1, 8'h75, 0, 0);
        q1.push_back({1'b1, 1'b1, 8'h75});
        checks++;
        if (cnt1 !== 3'd2) begin
            errors++;
            $display("FAIL extended conteo got=%0d want=2", cnt1);
        end
        drain1("extended");
    endtask

    task automatic test_held_level();
        @(negedge clk);
        dato1 = 8'h1C; rx1 = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt1 !== 3'd1 || head1 !== {2'b00, 8'h1C}) begin
            errors++;
            $display("FAIL held_latency conteo got=%0d head=%h want 1 / 01c", cnt1, head1);
        end
        repeat (399) @(negedge clk);
        rx1 = 1'b0;
        @(negedge clk);
        q1.push_back({1'b0, 1'b0, 8'h1C});
        checks++;
        if (cnt1 !== 3'd1) begin
            errors++;
            $display("FAIL held_level conteo got=%0d want=1", cnt1);
        end
        drain1("held_level");
    endtask

    task automatic test_overflow();
        send(1, 8'h15, 0, 0); q1.push_back({2'b00, 8'h15});
        send(1, 8'h1D, 0, 0); q1.push_back({2'b00, 8'h1D});
        send(1, 8'h24, 0, 0); q1.push_back({2'b00, 8'h24});
        send(1, 8'h2D, 0, 0); q1.push_back({2'b00, 8'h2D});
        send(1, 8'h2C, 0, 0);
        checks++;
        if (ll1 !== 1'b1 || de1 !== 1'b1 || cnt1 !== 3'd4) begin
            errors++;
            $display("FAIL overflow got lleno=%b desb=%b conteo=%0d want 1 1 4", ll1, de1, cnt1);
        end
        drain1("overflow");
        checks++;
        if (de1 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky desb got=%b want=1", de1);
        end
        @(negedge clk); limp1 = 1'b1;
        @(negedge clk); limp1 = 1'b0;
        checks++;
        if (de1 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear desb got=%b want=0", de1);
        end
    endtask

    task automatic test_full_push_pop();
        send(1, 8'h15, 0, 0); q1.push_back({2'b00, 8'h15});
        send(1, 8'h1D, 0, 0); q1.push_back({2'b00, 8'h1D});
        send(1, 8'h24, 0, 0); q1.push_back({2'b00, 8'h24});
        send(1, 8'h2D, 0, 0); q1.push_back({2'b00, 8'h2D});
        send(1, 8'h2C, 1, 0);
        void'(q1.pop_front());
        q1.push_back({2'b00, 8'h2C});
        checks++;
        if (cnt1 !== 3'd4 || de1 !== 1'b0 || ll1 !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop got conteo=%0d desb=%b lleno=%b want 4 0 1", cnt1, de1, ll1);
        end
        drain1("full_push_pop");
    endtask

    task automatic test_empty_edges();
        pop(1);
        checks++;
        if (cnt1 !== 3'd0 || va1 !== 1'b1) begin
            errors++;
            $display("FAIL leer_empty got conteo=%0d vacio=%b want 0 1", cnt1, va1);
        end
        send(1, 8'h16, 1, 0);
        q1.push_back({2'b00, 8'h16});
        checks++;
        if (cnt1 !== 3'd1) begin
            errors++;
            $display("FAIL empty_push_pop conteo got=%0d want=1", cnt1);
        end
        drain1("empty_push_pop");
    endtask

    task automatic test_limpiar();
        send(1, 8'h15, 0, 0);
        send(1, 8'h1D, 0, 0);
        send(1, 8'h24, 0, 1);
        checks++;
        if (cnt1 !== 3'd0 || va1 !== 1'b1 || head1 !== 10'h000) begin
            errors++;
            $display("FAIL limpiar got conteo=%0d vacio=%b head=%h want 0 1 000", cnt1, va1, head1);
        end
        send(0, 8'hF0, 0, 0);
        @(negedge clk); limp0 = 1'b1;
        @(negedge clk); limp0 = 1'b0;
        send(0, 8'h1C, 0, 0);
        q0.push_back({1'b0, 1'b1, 8'h1C});
        drain0("limpiar_keeps_fsm");
    endtask

    task automatic test_reset_prefix();
        send(0, 8'hF0, 0, 0);
        send(1, 8'hE0, 0, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        send(0, 8'h1C, 0, 0);
        send(1, 8'h75, 0, 0);
        q1.push_back({2'b00, 8'h75});
        checks++;
        if (va0 !== 1'b1 || cnt0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_prefix dut0 got vacio=%b conteo=%0d want 1 0", va0, cnt0);
        end
        drain1("reset_prefix");
    endtask

    task automatic test_reset_rx_high();
        @(negedge clk);
        dato1 = 8'h16; rx1 = 1'b1; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (va1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_rx_high vacio got=%b want=1", va1);
        end
        rx1 = 1'b0;
        repeat (2) @(negedge clk);
        rx1 = 1'b1;
        @(negedge clk);
        rx1 = 1'b0;
        q1.push_back({2'b00, 8'h16});
        checks++;
        if (cnt1 !== 3'd1) begin
            errors++;
            $display("FAIL reset_rx_rearm conteo got=%0d want=1", cnt1);
        end
        drain1("reset_rx_rearm");
    endtask

    initial begin
        dato0 = 8'h00; dato1 = 8'h00;
        rx0 = 1'b0; rx1 = 1'b0;
        leer0 = 1'b0; leer1 = 1'b0;
        limp0 = 1'b0; limp1 = 1'b0;
        test_reset();
        test_release_only();
        test_extended();
        test_held_level();
        test_overflow();
        test_full_push_pop();
        test_empty_edges();
        test_limpiar();
        test_reset_prefix();
        test_reset_rx_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
